// File: rtl/divider_seq_8bit_if.sv
// ---------------------------------------------------------------------------
// divider_seq_8bit_if
// Operand/result bundle for the iterative 8-bit unsigned divider.
//   start        request, sampled by the divider only when it is ready
//   a, b         dividend / divisor, captured on the accepting edge
//   quotient     registered result, valid with done and held afterwards
//   remainder    registered result, same validity as quotient
//   busy         high while the divider is iterating
//   done         one-cycle completion pulse
//   div_by_zero  set with done when the captured divisor was zero
// Modports: master = issuing datapath, slave = divider.
// ---------------------------------------------------------------------------
interface divider_seq_8bit_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, a, b,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/divider_seq_8bit.sv
// ---------------------------------------------------------------------------
// divider_seq_8bit
// Restoring unsigned 8-bit divider, one quotient bit per clock.
//   clk   rising-edge clock
//   rst   synchronous active-high reset (priority over start)
//   bus   divider_seq_8bit_if.slave: start/a/b in, quotient/remainder/
//         busy/done/div_by_zero out
// An accepted divide with b != 0 spends 8 cycles in BUSY, then one cycle
// in DONE with the results registered. A zero divisor jumps straight to
// DONE with quotient=FF, remainder=a and div_by_zero set. All outputs come
// straight from flops, so there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module divider_seq_8bit (
    input  logic                clk,
    input  logic                rst,
    divider_seq_8bit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] q_sh_q, q_sh_d;        // dividend shifting out / quotient shifting in
    logic [7:0] d_q, d_d;              // captured divisor
    // The partial remainder is architecturally 9 bits, but its top bit is
    // always 0 between iterations (R < D), so only the low 8 bits are held.
    logic [7:0] r_q, r_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quotient_q, quotient_d;
    logic [7:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic       ready;
    logic       accept;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept = ready && bus.start;

    // -----------------------------------------------------------------------
    // Trial subtract T = {R, Q[7]} - {0, D}, carry-lookahead form.
    // Subtraction is done as R' + ~{0,D} + 1; a carry out of bit 8 means
    // no borrow, i.e. the trial remainder is non-negative.
    // -----------------------------------------------------------------------
    logic [8:0] r_shift;
    logic [8:0] sub_b;
    logic [8:0] gen;
    logic [8:0] prop;
    logic [9:0] carry;
    logic [7:0] diff;
    logic       no_borrow;

    assign r_shift = {r_q, q_sh_q[7]};
    assign sub_b   = ~{1'b0, d_q};

    // Carry into bit n expanded directly from generate/propagate terms and
    // the carry-in, so each carry is an independent two-level function
    // rather than a chain through its neighbour.
    function automatic logic cla_carry(input logic [8:0] g,
                                       input logic [8:0] p,
                                       input int         n);
        logic c;
        c = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < n) begin
                c = g[k] | (p[k] & c);
            end
        end
        return c;
    endfunction

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_gp
            assign gen[gi]      = r_shift[gi] & sub_b[gi];
            assign prop[gi]     = r_shift[gi] ^ sub_b[gi];
            assign carry[gi+1]  = cla_carry(gen, prop, gi + 1);
        end
        // Bit 8 of the difference is only needed through its carry out.
        for (gi = 0; gi < 8; gi++) begin : g_sum
            assign diff[gi] = prop[gi] ^ carry[gi];
        end
    endgenerate

    assign no_borrow = carry[9];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = (bus.b == 8'd0) ? S_DONE : S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // -----------------------------------------------------------------------
    always_comb begin
        bus.busy = (state_q == S_BUSY);
        bus.done = (state_q == S_DONE);
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    logic [7:0] q_iter;
    logic [7:0] r_iter;

    always_comb begin
        q_iter = {q_sh_q[6:0], no_borrow};
        r_iter = no_borrow ? diff : r_shift[7:0];

        q_sh_d      = q_sh_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        if (accept) begin
            q_sh_d = bus.a;
            d_d    = bus.b;
            r_d    = 8'd0;
            cnt_d  = 3'd0;
            if (bus.b == 8'd0) begin
                quotient_d  = 8'hFF;
                remainder_d = bus.a;
                dbz_d       = 1'b1;
            end
        end else if (state_q == S_BUSY) begin
            q_sh_d = q_iter;
            r_d    = r_iter;
            cnt_d  = cnt_q + 3'd1;
            // Results are published only on the final iteration, so they
            // stay stable through IDLE and BUSY.
            if (cnt_q == 3'd7) begin
                quotient_d  = q_iter;
                remainder_d = r_iter;
                dbz_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_sh_q      <= 8'd0;
            d_q         <= 8'd0;
            r_q         <= 8'd0;
            cnt_q       <= 3'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            dbz_q       <= 1'b0;
        end else begin
            q_sh_q      <= q_sh_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

endmodule

// File: tb/tb_divider_seq_8bit.sv
// ---------------------------------------------------------------------------
// tb_divider_seq_8bit
// Directed and randomized checks of divider_seq_8bit against plain integer
// division (a / b, a % b) with the zero-divisor convention FF / a.
// ---------------------------------------------------------------------------
module tb_divider_seq_8bit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider_seq_8bit_if bus ();

    divider_seq_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int done_exp  = 0;

    // Count every done cycle independently of the directed steps.
    always @(negedge clk) begin
        if (!rst && bus.done) done_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE/DONE, wait for done, check everything.
    // Leaves the bench in the DONE cycle.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input string tag, input bit inv);
        int eq, er, lat;
        bit busy_ok;
        eq = (bv == 0) ? 255 : int'(av) / int'(bv);
        er = (bv == 0) ? int'(av) : int'(av) % int'(bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        done_exp++;
        check({tag, ".latency"}, lat, (bv == 0) ? 0 : 8);
        if (bv != 0) check({tag, ".busy_held"}, int'(busy_ok), 1);
        check({tag, ".done"}, int'(bus.done), 1);
        check({tag, ".busy_in_done"}, int'(bus.busy), 0);
        check({tag, ".quotient"}, int'(bus.quotient), eq);
        check({tag, ".remainder"}, int'(bus.remainder), er);
        check({tag, ".dbz"}, int'(bus.div_by_zero), (bv == 0) ? 1 : 0);
        if (inv && bv != 0) begin
            check({tag, ".identity"},
                  int'(bus.quotient) * int'(bv) + int'(bus.remainder), int'(av));
            check({tag, ".rem_lt_b"}, int'(bus.remainder < bv), 1);
        end
        $display("[TB] %s a=%0d b=%0d -> q=%0d r=%0d dbz=%0d lat=%0d",
                 tag, av, bv, bus.quotient, bus.remainder, bus.div_by_zero, lat);
    endtask

    initial begin
        int lat, lat2, cnt;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset.busy", int'(bus.busy), 0);
        check("reset.done", int'(bus.done), 0);
        check("reset.quotient", int'(bus.quotient), 0);
        check("reset.remainder", int'(bus.remainder), 0);
        check("reset.dbz", int'(bus.div_by_zero), 0);

        // Directed cases
        run_op(8'd200, 8'd7, "dir_200_7", 1'b1);
        tick();
        check("dir_200_7.pulse_end", int'(bus.done), 0);
        check("dir_200_7.idle_busy", int'(bus.busy), 0);
        check("dir_200_7.q_held", int'(bus.quotient), 28);
        run_op(8'd5, 8'd10, "dir_5_10", 1'b1);
        tick();
        run_op(8'd255, 8'd1, "dir_255_1", 1'b1);
        tick();
        run_op(8'd255, 8'd255, "dir_255_255", 1'b1);
        tick();
        run_op(8'd37, 8'd0, "dir_37_0", 1'b0);
        tick();
        check("dir_37_0.pulse_end", int'(bus.done), 0);
        check("dir_37_0.busy_after", int'(bus.busy), 0);

        // Start pulsed during BUSY must be ignored
        bus.a = 8'd100; bus.b = 8'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        tick(); lat++;
        tick(); lat++;
        check("ign.busy_c3", int'(bus.busy), 1);
        bus.a = 8'd50; bus.b = 8'd5; bus.start = 1'b1;
        tick(); lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        done_exp++;
        check("ign.latency", lat, 8);
        check("ign.quotient", int'(bus.quotient), 11);
        check("ign.remainder", int'(bus.remainder), 1);
        check("ign.dbz", int'(bus.div_by_zero), 0);
        $display("[TB] ign a=100 b=9 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);

        // Back-to-back accept from the DONE cycle
        bus.a = 8'd81; bus.b = 8'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b.done_drop", int'(bus.done), 0);
        check("b2b.busy", int'(bus.busy), 1);
        check("b2b.q_held", int'(bus.quotient), 11);
        lat2 = 0;
        while (!bus.done && lat2 < 20) begin
            tick();
            lat2++;
        end
        done_exp++;
        check("b2b.gap", lat2 + 1, 9);
        check("b2b.quotient", int'(bus.quotient), 9);
        check("b2b.remainder", int'(bus.remainder), 0);
        $display("[TB] b2b a=81 b=9 -> q=%0d r=%0d gap=%0d", bus.quotient, bus.remainder, lat2 + 1);
        tick();

        // Reset in the 4th BUSY cycle aborts with no done pulse
        bus.a = 8'd123; bus.b = 8'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("rst_mid.busy_c4", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.busy", int'(bus.busy), 0);
        check("rst_mid.done", int'(bus.done), 0);
        check("rst_mid.quotient", int'(bus.quotient), 0);
        check("rst_mid.remainder", int'(bus.remainder), 0);
        check("rst_mid.dbz", int'(bus.div_by_zero), 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) cnt++;
            tick();
        end
        check("rst_mid.no_done", cnt, 0);
        $display("[TB] rst_mid aborted, done pulses after reset=%0d", cnt);
        run_op(8'd60, 8'd7, "post_rst_60_7", 1'b1);
        tick();

        // Random sweep, mixing idle gaps and back-to-back issue
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] av, bv;
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(1, 255));
            run_op(av, bv, "sweep", 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check("sweep.pulse_end", int'(bus.done), 0);
            end
        end
        tick();
        tick();
        check("done_count", done_seen, done_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
